// File: rtl/decoder_3x8_seq.sv
// Buffered, timed 3-to-8 one-hot decoder. Codes arrive over valid/ready into a small FIFO.
// Each code is then shown on out as a one-hot byte for HOLD cycles.
module decoder_3x8_seq #(
  parameter  int DEPTH = 4,
  parameter  int HOLD  = 3,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [2:0]    in_code,
  output logic          in_ready,
  output logic [7:0]    out,
  output logic          out_valid,
  output logic [CW-1:0] count,
  output logic          drop_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic {IDLE, DRIVE} state_t;

  state_t        r_state, w_stateNext;
  logic [7:0]    r_out, w_outNext;
  logic          r_outValid, w_outValidNext;
  logic [HW-1:0] r_hold, w_holdNext;
  logic          r_dropErr;
  logic [AW-1:0] r_wrPtr, r_rdPtr;
  logic [CW-1:0] r_count;
  logic [2:0]    r_mem [DEPTH];
  logic          w_push, w_pop, w_ready;
  logic [7:0]    w_headOneHot;

  // Full blocks the producer even when a pop happens on the same edge.
  assign w_ready      = (r_count != CW'(DEPTH));
  assign w_push       = in_valid && w_ready;
  assign w_headOneHot = 8'b1 << r_mem[r_rdPtr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= in_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_count   <= '0;
      r_dropErr <= 1'b0;
    end else begin
      r_dropErr <= in_valid && !w_ready;
      if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_out      <= 8'h00;
      r_outValid <= 1'b0;
      r_hold     <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_out      <= w_outNext;
      r_outValid <= w_outValidNext;
      r_hold     <= w_holdNext;
    end
  end

  // Popping uses the registered count, so a code pushed this edge waits one cycle.
  always_comb begin
    w_stateNext    = r_state;
    w_outNext      = r_out;
    w_outValidNext = r_outValid;
    w_holdNext     = r_hold;
    w_pop          = 1'b0;
    case (r_state)
      IDLE: begin
        w_outNext      = 8'h00;
        w_outValidNext = 1'b0;
        if (r_count != '0) begin
          w_pop          = 1'b1;
          w_outNext      = w_headOneHot;
          w_outValidNext = 1'b1;
          w_holdNext     = HW'(HOLD - 1);
          w_stateNext    = DRIVE;
        end
      end
      DRIVE: begin
        if (r_hold != '0) begin
          w_holdNext = r_hold - HW'(1);
        end else if (r_count != '0) begin
          w_pop          = 1'b1;
          w_outNext      = w_headOneHot;
          w_outValidNext = 1'b1;
          w_holdNext     = HW'(HOLD - 1);
        end else begin
          w_outNext      = 8'h00;
          w_outValidNext = 1'b0;
          w_stateNext    = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  assign in_ready  = w_ready;
  assign out       = r_out;
  assign out_valid = r_outValid;
  assign count     = r_count;
  assign drop_err  = r_dropErr;

endmodule

// File: tb/tb_decoder_3x8_seq.sv
// Scoreboarded bench for decoder_3x8_seq: the driver queues accepted codes,
// a negedge monitor replays them as HOLD-cycle one-hot segments and compares.
module tb_decoder_3x8_seq;

  localparam int DEPTH = 4;
  localparam int HOLD  = 3;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid = 1'b0;
  logic [2:0]    in_code = 3'd0;
  logic          in_ready;
  logic [7:0]    out;
  logic          out_valid;
  logic [CW-1:0] count;
  logic          drop_err;

  decoder_3x8_seq #(.DEPTH(DEPTH), .HOLD(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_code(in_code),
    .in_ready(in_ready), .out(out), .out_valid(out_valid),
    .count(count), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: codes accepted but not yet shown, plus the segment being shown.
  logic [2:0] sbQ[$];
  logic [2:0] curCode = 3'd0;
  int         rem = 0;
  int         prevAvail = 0;
  logic       expDrop = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: a new segment starts when the previous one is done and a code was queued before the last edge.
  always @(negedge clk) begin
    logic       expValid;
    logic [7:0] expOut;
    if (rst_n) begin
      if (rem == 0 && prevAvail > 0) begin
        curCode = sbQ.pop_front();
        rem     = HOLD;
      end
      expValid = (rem > 0);
      expOut   = expValid ? (8'd1 << curCode) : 8'h00;
      checkOutput("out", out, expOut);
      checkOutput("out_valid", out_valid, expValid);
      checkOutput("count", count, sbQ.size());
      checkOutput("in_ready", in_ready, sbQ.size() != DEPTH);
      checkOutput("drop_err", drop_err, expDrop);
      checkOutput("onehot0", $onehot0(out), 1);
      checkOutput("validConsistent", (out != 8'h00), out_valid);
      if (rem > 0) rem--;
      prevAvail = sbQ.size();
    end
  end

  task automatic applyStimulus(input logic v, input logic [2:0] c, input logic honour, output logic acc);
    logic vEff, drop;
    @(negedge clk);
    vEff     = v && (!honour || in_ready);
    in_valid = vEff;
    in_code  = c;
    acc      = vEff && in_ready;
    drop     = vEff && !in_ready;
    @(posedge clk);
    if (acc) sbQ.push_back(c);
    expDrop = drop;
  endtask

  task automatic idleCycles(input int n);
    logic acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'($urandom_range(0, 7)), 1'b1, acc);
  endtask

  task automatic pushCode(input logic [2:0] c);
    logic acc;
    acc = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) applyStimulus(1'b1, c, 1'b1, acc);
    checkOutput("pushAccepted", acc, 1);
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      if (sbQ.size() == 0 && rem == 0) done = 1'b1;
      else idleCycles(1);
    end
    checkOutput("drainDone", done, 1);
  endtask

  task automatic clearModel();
    sbQ.delete();
    rem       = 0;
    prevAvail = 0;
    expDrop   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic acc;
    logic [2:0] fill [6];
    fill = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd6, 3'd7};

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rstOut", out, 8'h00);
    checkOutput("rstValid", out_valid, 0);
    checkOutput("rstCount", count, 0);
    checkOutput("rstDrop", drop_err, 0);
    checkOutput("rstReady", in_ready, 1);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Single code while idle.
    pushCode(3'd5);
    drain();

    // Stream 0..7 honouring in_ready.
    for (int i = 0; i < 8; i++) pushCode(3'(i));
    drain();

    // Fill to full from idle, then offer code 2 twice while full.
    for (int i = 0; i < 6; i++) pushCode(fill[i]);
    applyStimulus(1'b1, 3'd2, 1'b0, acc);
    checkOutput("stallDrop1", acc, 0);
    applyStimulus(1'b1, 3'd2, 1'b0, acc);
    checkOutput("stallDrop2", acc, 0);
    drain();

    // 7 then 0, four cycles apart: idle gap expected between them.
    pushCode(3'd7);
    idleCycles(3);
    pushCode(3'd0);
    drain();

    // Wrap-around: ten codes through the pointers.
    for (int i = 0; i < 10; i++) pushCode(3'((i * 3 + 1) % 8));
    drain();

    // Randomized traffic, sometimes ignoring in_ready.
    for (int i = 0; i < 300; i++)
      applyStimulus($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, acc);
    drain();

    // Asynchronous reset in the middle of driving 8'h20.
    pushCode(3'd5);
    idleCycles(1);
    #2;
    checkOutput("preResetOut", out, 8'h20);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstOut", out, 8'h00);
    checkOutput("midRstValid", out_valid, 0);
    checkOutput("midRstCount", count, 0);
    checkOutput("midRstDrop", drop_err, 0);
    clearModel();
    @(negedge clk);
    #1 rst_n = 1'b1;

    pushCode(3'd3);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
